// File: rtl/timer_pkg.sv
// Shared types and BCD limits for the bomb-timer countdown controller.
package timer_pkg;

  typedef enum logic [2:0] {IDLE, RUN, PAUSE, BOOM, DEFUSED} state_e;

  localparam logic [3:0] BCD_MAX_ONE = 4'd9;
  localparam logic [2:0] BCD_MAX_TEN = 3'd5;

  function automatic logic [2:0] clamp_ten(input logic [2:0] v);
    return (v > BCD_MAX_TEN) ? BCD_MAX_TEN : v;
  endfunction

  function automatic logic [3:0] clamp_one(input logic [3:0] v);
    return (v > BCD_MAX_ONE) ? BCD_MAX_ONE : v;
  endfunction

endpackage

// File: rtl/countdown_scan_controller_pulse_divider.sv
// Enabled prescaler: one-cycle pulse every DIV enabled cycles; clr restarts the count.
module pulse_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic pulse
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign pulse = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= pulse ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/countdown_scan_controller.sv
// Two-digit BCD seconds countdown with game-state FSM, preset load and display scan select.
module countdown_scan_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int SCAN_DIV  = 50_000,
  parameter int START_TEN = 5,
  parameter int START_ONE = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       defuse,
  input  logic       load,
  input  logic [2:0] loadTen,
  input  logic [3:0] loadOne,
  output logic [2:0] ten,
  output logic [3:0] one,
  output logic       scanSel,
  output logic       bomb,
  output logic       running
);

  state_e     state;
  logic [2:0] pre_ten;
  logic [3:0] pre_one;
  logic [2:0] ld_ten;
  logic [3:0] ld_one;
  logic       sec_tick, scan_pulse, tick_clr, at_zero, last_sec;

  assign ld_ten   = clamp_ten(loadTen);
  assign ld_one   = clamp_one(loadOne);
  assign at_zero  = (ten == 3'd0) && (one == 4'd0);
  assign last_sec = (ten == 3'd0) && (one == 4'd1);
  // Fresh arm from IDLE restarts the second; resume from PAUSE keeps the partial second.
  assign tick_clr = (state == IDLE) && start && !load;

  pulse_divider #(.DIV(TICK_DIV)) u_tick (
    .clk(clk), .rst_n(rst_n), .en(state == RUN), .clr(tick_clr), .pulse(sec_tick)
  );

  pulse_divider #(.DIV(SCAN_DIV)) u_scan (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .pulse(scan_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ten     <= 3'(START_TEN);
      one     <= 4'(START_ONE);
      pre_ten <= 3'(START_TEN);
      pre_one <= 4'(START_ONE);
      scanSel <= 1'b0;
      bomb    <= 1'b0;
      running <= 1'b0;
    end else begin
      if (scan_pulse) scanSel <= ~scanSel;
      case (state)
        IDLE: begin
          if (load) begin
            pre_ten <= ld_ten;
            pre_one <= ld_one;
            ten     <= ld_ten;
            one     <= ld_one;
          end else if (start) begin
            if (at_zero) begin
              state <= BOOM;
              bomb  <= 1'b1;
            end else begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end
        RUN: begin
          if (defuse) begin
            state   <= DEFUSED;
            running <= 1'b0;
          end else if (pause) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (sec_tick) begin
            if (one == 4'd0) begin
              one <= BCD_MAX_ONE;
              ten <= ten - 3'd1;
            end else begin
              one <= one - 4'd1;
            end
            // 01 -> 00 explodes on the same edge; 00 is never held in RUN.
            if (last_sec) begin
              state   <= BOOM;
              bomb    <= 1'b1;
              running <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (defuse) begin
            state <= DEFUSED;
          end else if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        BOOM, DEFUSED: begin
          if (start) begin
            state <= IDLE;
            bomb  <= 1'b0;
            ten   <= pre_ten;
            one   <= pre_one;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          bomb    <= 1'b0;
        end
      endcase
    end
  end

endmodule
